// File: rtl/dnn_acc_pkg.sv
// rtl/dnn_acc_pkg.sv - shared FSM state type and beat-size helper for the BRAM burst controller
package dnn_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Bytes moved per beat; the address advances by this much on every beat.
  function automatic int unsigned bytes_per_beat(input int unsigned dat_width);
    return dat_width / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// rtl/bram_rd_fifo.sv - read-return buffer holding BRAM data plus last-beat tag
module bram_rd_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full buffer is accepted only when a pop frees a slot the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != (PTR_W+1)'(DEPTH)) || w_pop);

  // Pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/bram_burst_ctrl.sv
// rtl/bram_burst_ctrl.sv - burst read/write controller in front of a fixed-latency BRAM
module bram_burst_ctrl
  import dnn_acc_pkg::*;
#(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [DAT_WIDTH-1:0]   wdat,
  input  logic [DAT_WIDTH/8-1:0] wben,
  input  logic                   wval,
  output logic                   wrdy,
  output logic [DAT_WIDTH-1:0]   rdat,
  output logic                   rval,
  input  logic                   rrdy,
  output logic                   rlast,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DAT_WIDTH-1:0]   mem_idat,
  input  logic [DAT_WIDTH-1:0]   mem_odat,
  output logic                   mem_enb,
  output logic                   mem_rst,
  output logic [DAT_WIDTH/8-1:0] mem_wen
);

  localparam int unsigned BPB   = bytes_per_beat(DAT_WIDTH);
  localparam int          CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_cnt;
  logic [RD_LATENCY-1:0]   r_pipe_vld;
  logic [RD_LATENCY-1:0]   r_pipe_last;

  logic                    w_cmd_fire;
  logic                    w_wr_beat;
  logic                    w_rd_issue;
  logic                    w_last_beat;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_empty;
  logic                    w_credit;
  logic [CNT_W-1:0]        w_fifo_cnt;
  logic [CNT_W-1:0]        w_pipe_cnt;
  logic [CNT_W:0]          w_inflight;
  logic [DAT_WIDTH:0]      w_fifo_head;

  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_last_beat = (r_cnt == r_len);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: a burst ends on its (len+1)-th beat; reads then drain the return path.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_fire) w_next_state = cmd_wr ? ST_WRITE : ST_READ;
      ST_WRITE: if (w_wr_beat && w_last_beat) w_next_state = ST_IDLE;
      ST_READ:  if (w_rd_issue && w_last_beat) w_next_state = ST_DRAIN;
      ST_DRAIN: if ((w_pipe_cnt == '0) && w_fifo_empty) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs; everything is held off during the reset cycle so nothing reaches the BRAM.
  always_comb begin
    cmd_ready  = 1'b0;
    wrdy       = 1'b0;
    busy       = 1'b0;
    w_wr_beat  = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      ST_IDLE:  cmd_ready = !rst;
      ST_WRITE: begin
        busy      = 1'b1;
        wrdy      = !rst;
        w_wr_beat = wval && !rst;
      end
      ST_READ: begin
        busy       = 1'b1;
        w_rd_issue = w_credit && !rst;
      end
      ST_DRAIN: busy = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  // Burst address and beat counter: loaded on the command, advanced once per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (w_cmd_fire) begin
      r_addr <= cmd_addr;
      r_len  <= cmd_len;
      r_cnt  <= '0;
    end else if (w_wr_beat || w_rd_issue) begin
      r_addr <= r_addr + ADDR_WIDTH'(BPB);
      r_cnt  <= r_cnt + LEN_WIDTH'(1);
    end
  end

  // Shadow of the BRAM read pipeline: marks which cycles carry valid read data and the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
    end else begin
      r_pipe_vld[0]  <= w_rd_issue;
      r_pipe_last[0] <= w_rd_issue && w_last_beat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
    end
  end

  // Reads in flight in the BRAM pipe.
  always_comb begin
    w_pipe_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_pipe_cnt = w_pipe_cnt + CNT_W'(r_pipe_vld[i]);
    end
  end

  // A new read may issue only if every read already in flight still has a buffer slot;
  // a pop this cycle frees one, which keeps back-to-back reads flowing at minimum depth.
  assign w_inflight = {1'b0, w_pipe_cnt} + {1'b0, w_fifo_cnt} - {{CNT_W{1'b0}}, w_pop};
  assign w_credit   = (w_inflight < (CNT_W+1)'(FIFO_DEPTH));

  assign w_push = r_pipe_vld[RD_LATENCY-1];
  assign w_pop  = rval && rrdy;

  bram_rd_fifo #(
    .WIDTH (DAT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_pipe_last[RD_LATENCY-1], mem_odat}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  assign rval  = !w_fifo_empty;
  assign rdat  = rval ? w_fifo_head[DAT_WIDTH-1:0] : '0;
  assign rlast = rval && w_fifo_head[DAT_WIDTH];

  assign mem_addr = r_addr;
  assign mem_idat = wdat;
  assign mem_wen  = w_wr_beat ? wben : '0;
  assign mem_enb  = 1'b1;
  assign mem_rst  = rst;

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// tb/tb_bram_burst_ctrl.sv - directed self-checking bench for bram_burst_ctrl
module tb_bram_burst_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LW    = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] wdat;
  logic [3:0]    wben;
  logic          wval;
  logic          wrdy;
  logic [DW-1:0] rdat;
  logic          rval;
  logic          rrdy;
  logic          rlast;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_idat;
  logic [DW-1:0] mem_odat;
  logic          mem_enb;
  logic          mem_rst;
  logic [3:0]    mem_wen;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   rd_addr0;
  logic [31:0]   rd_addr1;
  int            rd_first_k;

  logic [31:0]   bram [256];
  logic [31:0]   rd1;
  logic [31:0]   rd2;

  always #5 clk = ~clk;

  bram_burst_ctrl #(
    .DAT_WIDTH  (DW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .RD_LATENCY (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wdat      (wdat),
    .wben      (wben),
    .wval      (wval),
    .wrdy      (wrdy),
    .rdat      (rdat),
    .rval      (rval),
    .rrdy      (rrdy),
    .rlast     (rlast),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_idat  (mem_idat),
    .mem_odat  (mem_odat),
    .mem_enb   (mem_enb),
    .mem_rst   (mem_rst),
    .mem_wen   (mem_wen)
  );

  // Two-cycle-latency BRAM, word-indexed by address bits [9:2].
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_wen[b]) bram[mem_addr[9:2]][b*8 +: 8] <= mem_idat[b*8 +: 8];
    end
    rd1 <= bram[mem_addr[9:2]];
    rd2 <= rd1;
  end
  assign mem_odat = rd2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(i));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input logic [3:0] be,
                          input logic [7:0] gap_mask);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = addr; cmd_len = len;
    #1 chk("wr_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (gap_mask[b]) begin
        wval = 1'b0;
        #1 chk("wr_gap_wen", mem_wen, 0);
        @(negedge clk);
      end
      wval = 1'b1; wdat = base + 32'(b); wben = be;
      #1;
      chk("wr_wrdy", wrdy, 1);
      chk("wr_wen", mem_wen, be);
      chk("wr_addr", mem_addr, addr + 32'(4 * b));
      @(negedge clk);
    end
    wval = 1'b0;
    #1;
    chk("wr_done_ready", cmd_ready, 1);
    chk("wr_done_busy", busy, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input int stall, input int rst_beat);
    int  beat;
    int  k;
    bit  done;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = addr; cmd_len = len;
    #1 chk("rd_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    beat = 0; k = 0; done = 1'b0; rd_first_k = -1;
    while (!done && beat <= int'(len) && k < 200) begin
      rrdy = (k >= stall);
      #1;
      if (k == 0) rd_addr0 = mem_addr;
      if (k == 1) rd_addr1 = mem_addr;
      if (stall > 0 && k == stall - 1) begin
        chk("rd_stall_issues", mem_addr, addr + 32'(4 * DEPTH));
        chk("rd_stall_rval", rval, 1);
        chk("rd_stall_hold", rdat, exp_q[0]);
      end
      if (rval && rrdy) begin
        if (rd_first_k < 0) rd_first_k = k;
        if (stall == 0 && beat > 0) chk("rd_back2back", k, rd_first_k + beat);
        chk("rd_data", rdat, exp_q[beat]);
        chk("rd_last", rlast, (beat == int'(len)));
        if (beat == rst_beat) begin
          rst  = 1'b1;
          done = 1'b1;
        end else begin
          beat++;
        end
      end
      @(negedge clk);
      k++;
    end
    if (!done && beat <= int'(len)) chk("rd_timeout", beat, int'(len) + 1);
  endtask

  task automatic wait_idle();
    int n;
    logic got;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      #1 got = cmd_ready;
      if (!got) @(negedge clk);
      n++;
    end
    chk("idle_ready", got, 1);
  endtask

  initial begin
    int stale;
    for (int i = 0; i < 256; i++) bram[i] = 32'hC000_0000 | 32'(i);
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdat = '0; wben = '0; wval = 1'b0; rrdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wrdy", wrdy, 0);
    chk("rst_rval", rval, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdat", rdat, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_enb", mem_enb, 1);

    // Full-word write burst of four beats starting at 0x10.
    do_write(32'h10, 8'd3, 32'hA0, 4'hF, 8'h00);

    // Read it back at full rate; first beat three edges after the handshake.
    fill_seq(32'hA0, 4);
    do_read(32'h10, 8'd3, 0, -1);
    chk("rd_first_latency", rd_first_k, LAT + 1);
    wait_idle();

    // Single-beat burst.
    fill_seq(32'hA0, 1);
    do_read(32'h10, 8'd0, 0, -1);
    wait_idle();

    // Address wrap at the top of the space.
    exp_q.delete();
    exp_q.push_back(32'hC000_00FF);
    exp_q.push_back(32'hC000_0000);
    do_read(32'hFFFF_FFFC, 8'd1, 0, -1);
    chk("wrap_addr0", rd_addr0, 32'hFFFF_FFFC);
    chk("wrap_addr1", rd_addr1, 32'h0000_0000);
    wait_idle();

    // Eight-beat read with the consumer stalled for six cycles.
    fill_seq(32'hC000_0010, 8);
    do_read(32'h40, 8'd7, 6, -1);
    wait_idle();

    // Half-word write with idle gaps, then read back the merged words.
    do_write(32'h80, 8'd2, 32'h5566_7700, 4'h3, 8'b0000_0110);
    fill_seq(32'hC000_7700, 3);
    do_read(32'h80, 8'd2, 0, -1);
    wait_idle();

    // Reset during the third beat of an eight-beat read.
    fill_seq(32'hC000_0010, 8);
    do_read(32'h40, 8'd7, 0, 2);
    rst = 1'b0;
    #1;
    chk("abort_rval", rval, 0);
    chk("abort_rlast", rlast, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    @(negedge clk);
    #1 chk("abort_ready_next", cmd_ready, 1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      #1 if (rval) stale++;
    end
    chk("abort_no_stale", stale, 0);

    // Normal operation resumes after the abort.
    fill_seq(32'hC000_0010, 2);
    do_read(32'h40, 8'd1, 0, -1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/bram_burst_ctrl.md
BRAM_BURST_CTRL -- requirements
Module: bram_burst_ctrl

Interface
REQ-001 SHALL have parameter DAT_WIDTH, default 32, user/BRAM data width; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 SHALL have parameter RD_LATENCY, default 1, BRAM read latency in cycles; legal range 1..3.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, read-return buffer depth; power of 2, at least RD_LATENCY+1.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port cmd_valid / cmd_ready, input / output, 1 each, command handshake.
REQ-009 SHALL have port cmd_wr, input, 1, 1 = write burst, 0 = read burst.
REQ-010 SHALL have port cmd_addr, input, ADDR_WIDTH, start byte address.
REQ-011 SHALL have port cmd_len, input, LEN_WIDTH, beats minus 1.
REQ-012 SHALL have port wdat / wben, input, DAT_WIDTH / DAT_WIDTH/8, write data and byte enables.
REQ-013 SHALL have port wval / wrdy, input / output, 1 each, write beat handshake.
REQ-014 SHALL have port rdat, output, DAT_WIDTH, read data.
REQ-015 SHALL have port rval / rrdy, output / input, 1 each, read beat handshake.
REQ-016 SHALL have port rlast, output, 1, final read beat marker.
REQ-017 SHALL have port busy, output, 1, high whenever not IDLE.
REQ-018 SHALL have BRAM-side ports mem_addr (ADDR_WIDTH), mem_idat (DAT_WIDTH), mem_odat (input, DAT_WIDTH), mem_enb (1), mem_rst (1), mem_wen (DAT_WIDTH/8), all outputs except mem_odat.

Function
REQ-019 SHALL implement FSM IDLE, WRITE, READ, DRAIN; cmd_ready=1 only in IDLE; a handshake latches addr, len and wr in the same edge.
REQ-020 SHALL transition IDLE->WRITE when cmd_wr=1, else IDLE->READ.
REQ-021 In WRITE: wrdy=1; each wval&wrdy beat drives mem_addr=current addr, mem_idat=wdat, mem_wen=wben combinationally, same cycle.
REQ-022 In WRITE: addr advances by DAT_WIDTH/8 per beat; after beat len+1, FSM -> IDLE.
REQ-023 In WRITE, wval low inserts idle cycles with mem_wen=0 and no address advance.
REQ-024 In READ: a read is issued (mem_addr=addr, mem_wen=0) only when outstanding-in-pipe + FIFO occupancy < FIFO_DEPTH; each issue advances addr.
REQ-025 Each issued read's mem_odat SHALL be pushed into the FIFO exactly RD_LATENCY cycles after issue, tagged last if it is beat len.
REQ-026 After last issue, FSM -> DRAIN; DRAIN -> IDLE when pipe empty, FIFO empty and no beat pending.
REQ-027 rval = FIFO not empty; rdat/rlast = FIFO head; pop on rval&rrdy; rdat/rlast stable while rval&!rrdy.
REQ-028 With rrdy held high, sustained throughput SHALL be one beat per cycle; first rval RD_LATENCY+1 cycles after the command handshake.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no error on wrap.
REQ-030 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; overflow is impossible by REQ-024.
REQ-031 mem_enb=1 constantly; mem_rst=rst.
REQ-032 cmd_len=0 SHALL perform exactly one beat.

Reset
REQ-033 On rst: state=IDLE, FIFO and pipe empty; cmd_ready=1 on the cycle after reset deasserts; wrdy, rval, rlast, busy, mem_wen=0; rdat=0; mem_addr=0.
REQ-034 Reset mid-burst SHALL abort the burst; in-flight read data is discarded, no write issued on the reset cycle.

Structure
REQ-035 SHALL place the FSM state enum and the byte-per-beat constant in shared package dnn_acc_pkg.
REQ-036 SHALL instantiate read-return FIFO as sub-module bram_rd_fifo (data+last, parameter width/depth, sync reset).

Verification
REQ-037 SHALL cover a write with addr 0x10, len 3, data 0xA0..0xA3, wben 0xF: mem_wen=0xF at 0x10, 0x14, 0x18, 0x1C, then cmd_ready=1.
REQ-038 SHALL cover a read with addr 0x10, len 3, rrdy=1, RD_LATENCY=2: beats 0xA0..0xA3 on consecutive cycles, first at cycle 3 after handshake, rlast on 0xA3 only.
REQ-039 SHALL cover a read with len 7 and rrdy=0 for 6 cycles: at most FIFO_DEPTH issues, no loss, then 8 in-order beats.
REQ-040 SHALL cover a read at addr 0xFFFFFFFC with len 1: mem_addr sequence 0xFFFFFFFC, 0x00000000.
REQ-041 SHALL cover a partial write with wben 0x3 plus wval gaps: mem_wen=0x3 only on handshake cycles.
REQ-042 SHALL cover rst asserted at beat 2 of an 8-beat read: rval=0 next cycle, cmd_ready=1 the following cycle, no stale beats afterwards.
